sobel_line_buf: RTL and testbench

//  Front end of the Sobel datapath. Takes a raster pixel stream (one 8-bit pixel per beat)
//  and emits three vertically aligned row taps per column for sobel_data_mod's d0_i/d1_i/d2_i/done_i inputs:
//  d0_o = row r-2, d1_o = row r-1, d2_o = row r (current).

---
 rtl/sobel_line_buf_if.sv | 50 +++++
 rtl/sobel_line_buf.sv | 112 +++++++++++
 tb/tb_sobel_line_buf.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sobel_line_buf_if.sv
// ---------------------------------------------------------------------------
// sobel_line_buf_if
//   Bundles the pixel-stream input and the three-tap output of sobel_line_buf.
//   The master side drives the raster stream and receives the taps.
//   The slave side is the line buffer itself.
//
//   Signals
//     pix_i        DW  input pixel, raster order
//     done_i       1   pix_i valid this cycle (low = stall)
//     d0_o         DW  pixel at (r-2, c)
//     d1_o         DW  pixel at (r-1, c)
//     d2_o         DW  pixel at (r, c)
//     done_o       1   taps valid, one pulse per accepted pixel past warm-up
//     frame_end_o  1   last tap of the frame (only with SOBEL_LB_FRAME_END_EN)
//
//   Optional feature macro: SOBEL_LB_FRAME_END_EN
// ---------------------------------------------------------------------------
interface sobel_line_buf_if #(
    parameter int DW = 8
);
    logic [DW-1:0] pix_i;
    logic          done_i;
    logic [DW-1:0] d0_o;
    logic [DW-1:0] d1_o;
    logic [DW-1:0] d2_o;
    logic          done_o;
`ifdef SOBEL_LB_FRAME_END_EN
    logic          frame_end_o;

    modport master (
        output pix_i, done_i,
        input  d0_o, d1_o, d2_o, done_o, frame_end_o
    );

    modport slave (
        input  pix_i, done_i,
        output d0_o, d1_o, d2_o, done_o, frame_end_o
    );
`else
    modport master (
        output pix_i, done_i,
        input  d0_o, d1_o, d2_o, done_o
    );

    modport slave (
        input  pix_i, done_i,
        output d0_o, d1_o, d2_o, done_o
    );
`endif
endinterface

// File: rtl/sobel_line_buf.sv
// ---------------------------------------------------------------------------
// sobel_line_buf
//   Front end of the Sobel datapath. Accepts one pixel per beat in raster
//   order and emits three vertically aligned taps per column:
//   d0_o = row r-2, d1_o = row r-1, d2_o = row r. Two COLS-deep line
//   memories hold the two previous rows. A column/row counter tracks the
//   raster position so the first two rows of each frame act as warm-up.
//
//   Parameters
//     ROWS  image height in lines (>= 3)
//     COLS  image width in pixels (>= 1)
//     DW    pixel width in bits
//
//   Ports
//     clk   system clock, rising edge
//     rst   synchronous, active-high reset
//     bus   sobel_line_buf_if slave modport (pix_i/done_i in,
//           d0_o/d1_o/d2_o/done_o out, frame_end_o when enabled)
//
//   Optional feature macro: SOBEL_LB_FRAME_END_EN
//     When defined, frame_end_o pulses with done_o for the beat accepted at
//     (ROWS-1, COLS-1) so downstream can flush its window pipeline.
// ---------------------------------------------------------------------------
module sobel_line_buf #(
    parameter int ROWS = 5,
    parameter int COLS = 6,
    parameter int DW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    sobel_line_buf_if.slave  bus
);

    // A single-column image still needs a one-bit column counter.
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = $clog2(ROWS);

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_FIRST_LIVE = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [DW-1:0] lb0 [COLS];
    logic [DW-1:0] lb1 [COLS];

    logic accept;
    logic col_last;
    logic row_last;
    logic row_live;

    assign accept   = bus.done_i;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign row_live = (row >= ROW_FIRST_LIVE);

    // Raster position. Column wraps into the next row; the row wrap starts a
    // new frame, which restarts warm-up without needing an idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line memories shift one row down per accepted pixel. They are never
    // cleared: warm-up rows keep stale contents from reaching done_o.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb0[col] <= lb1[col];
            lb1[col] <= bus.pix_i;
        end
    end

    // Output taps use the pre-write memory values, giving d0 = r-2 and
    // d1 = r-1. During a stall the taps hold and done_o drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.d0_o   <= '0;
            bus.d1_o   <= '0;
            bus.d2_o   <= '0;
            bus.done_o <= 1'b0;
        end else begin
            bus.done_o <= accept && row_live;
            if (accept) begin
                bus.d0_o <= lb0[col];
                bus.d1_o <= lb1[col];
                bus.d2_o <= bus.pix_i;
            end
        end
    end

`ifdef SOBEL_LB_FRAME_END_EN
    // Marks the tap produced by the last pixel of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.frame_end_o <= 1'b0;
        end else begin
            bus.frame_end_o <= accept && row_last && col_last;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_line_buf.sv
// ---------------------------------------------------------------------------
// tb_sobel_line_buf
//   Directed bench for sobel_line_buf. A 5x6 instance sees pixel values
//   v = base + 6*row + col, so the taps of every live beat are v-12, v-6, v.
//   A 3x1 instance covers the single-column edge case.
// ---------------------------------------------------------------------------
module tb_sobel_line_buf;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sobel_line_buf_if #(.DW(8)) bus  ();
    sobel_line_buf_if #(.DW(8)) sbus ();

    sobel_line_buf #(.ROWS(5), .COLS(6), .DW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sobel_line_buf #(.ROWS(3), .COLS(1), .DW(8)) u_dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock of stimulus on the 5x6 instance; returns #1 after the edge.
    task automatic applyStimulus(input logic [7:0] pix, input logic vld);
        @(negedge clk);
        bus.pix_i  = pix;
        bus.done_i = vld;
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus on the 3x1 instance.
    task automatic applySmall(input logic [7:0] pix, input logic vld);
        @(negedge clk);
        sbus.pix_i  = pix;
        sbus.done_i = vld;
        @(posedge clk);
        #1;
    endtask

    // One-cycle reset, optionally with done_i high to show it is ignored.
    task automatic resetDut(input logic vld, input string tag);
        @(negedge clk);
        rst        = 1'b1;
        bus.pix_i  = 8'hAA;
        bus.done_i = vld;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.done_i = 1'b0;
        checkOutput({tag, "_rst_d0"},   32'(bus.d0_o),   32'd0);
        checkOutput({tag, "_rst_d1"},   32'(bus.d1_o),   32'd0);
        checkOutput({tag, "_rst_d2"},   32'(bus.d2_o),   32'd0);
        checkOutput({tag, "_rst_done"}, 32'(bus.done_o), 32'd0);
`ifdef SOBEL_LB_FRAME_END_EN
        checkOutput({tag, "_rst_fe"},   32'(bus.frame_end_o), 32'd0);
`endif
    endtask

    // Feeds nBeats pixels starting at base. After the beat carrying stallVal
    // the stream pauses for three cycles with a junk pixel on the bus.
    task automatic runFrame(input int base, input int nBeats, input int stallVal, input string tag);
        int pulses;
        int v;
        logic expDone;
        pulses = 0;
        for (int i = 0; i < nBeats; i++) begin
            v       = base + i;
            expDone = (i >= 12);
            applyStimulus(8'(v), 1'b1);
            if (bus.done_o) pulses++;
            checkOutput({tag, "_done"}, 32'(bus.done_o), 32'(expDone));
            checkOutput({tag, "_d2"},   32'(bus.d2_o),   32'(v));
            if (expDone) begin
                checkOutput({tag, "_d0"}, 32'(bus.d0_o), 32'(v - 12));
                checkOutput({tag, "_d1"}, 32'(bus.d1_o), 32'(v - 6));
            end
`ifdef SOBEL_LB_FRAME_END_EN
            checkOutput({tag, "_fe"}, 32'(bus.frame_end_o), 32'(i == 29));
`endif
            if (v == stallVal) begin
                for (int s = 0; s < 3; s++) begin
                    applyStimulus(8'hEE, 1'b0);
                    if (bus.done_o) pulses++;
                    checkOutput({tag, "_stall_done"}, 32'(bus.done_o), 32'd0);
                    checkOutput({tag, "_stall_d0"},   32'(bus.d0_o),   32'(v - 12));
                    checkOutput({tag, "_stall_d1"},   32'(bus.d1_o),   32'(v - 6));
                    checkOutput({tag, "_stall_d2"},   32'(bus.d2_o),   32'(v));
                end
            end
        end
        if (nBeats == 30) begin
            checkOutput({tag, "_pulses"}, 32'(pulses), 32'd18);
        end
    endtask

    initial begin
        int spulses;
        rst         = 1'b0;
        bus.pix_i   = '0;
        bus.done_i  = 1'b0;
        sbus.pix_i  = '0;
        sbus.done_i = 1'b0;

        // Scenario 1: one continuous frame, then an idle cycle holding 18/24/30.
        $display("[TB] scenario 1: continuous frame");
        resetDut(1'b0, "s1");
        runFrame(1, 30, 0, "s1");
        applyStimulus(8'h55, 1'b0);
        checkOutput("s1_idle_done", 32'(bus.done_o), 32'd0);
        checkOutput("s1_idle_d0",   32'(bus.d0_o),   32'd18);
        checkOutput("s1_idle_d1",   32'(bus.d1_o),   32'd24);
        checkOutput("s1_idle_d2",   32'(bus.d2_o),   32'd30);

        // Scenario 2: three-cycle stall after v=15.
        $display("[TB] scenario 2: stall");
        resetDut(1'b0, "s2");
        runFrame(1, 30, 15, "s2");

        // Scenario 3: two frames back-to-back, no idle cycle between them.
        $display("[TB] scenario 3: back-to-back frames");
        resetDut(1'b0, "s3");
        runFrame(1, 30, 0, "s3a");
        runFrame(101, 30, 0, "s3b");

        // Scenario 4: reset mid-frame with done_i high, then a full frame.
        $display("[TB] scenario 4: mid-frame reset");
        resetDut(1'b0, "s4");
        runFrame(1, 20, 0, "s4pre");
        resetDut(1'b1, "s4");
        runFrame(1, 30, 0, "s4");

        // Scenario 6: single-column, three-row image.
        $display("[TB] scenario 6: COLS=1 ROWS=3");
        resetDut(1'b0, "s6");
        spulses = 0;
        applySmall(8'd7, 1'b1);
        if (sbus.done_o) spulses++;
        checkOutput("s6_b1_done", 32'(sbus.done_o), 32'd0);
        applySmall(8'd8, 1'b1);
        if (sbus.done_o) spulses++;
        checkOutput("s6_b2_done", 32'(sbus.done_o), 32'd0);
        applySmall(8'd9, 1'b1);
        if (sbus.done_o) spulses++;
        checkOutput("s6_b3_done", 32'(sbus.done_o), 32'd1);
        checkOutput("s6_d0",      32'(sbus.d0_o),   32'd7);
        checkOutput("s6_d1",      32'(sbus.d1_o),   32'd8);
        checkOutput("s6_d2",      32'(sbus.d2_o),   32'd9);
`ifdef SOBEL_LB_FRAME_END_EN
        checkOutput("s6_fe",      32'(sbus.frame_end_o), 32'd1);
`endif
        applySmall(8'd0, 1'b0);
        if (sbus.done_o) spulses++;
        checkOutput("s6_idle_done", 32'(sbus.done_o), 32'd0);
        checkOutput("s6_pulses",    32'(spulses),     32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
